// File: rtl/f8_sim_sequencer.sv
// f8_sim_sequencer: run controller for f8 system-level tests.
// Sequences the system reset, counts run cycles, watches trap/pass/timeout
// events and ends every run in a sticky, encoded verdict.
module f8_sim_sequencer #(
    parameter int RESET_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 2045,
    parameter int DRAIN_CYCLES   = 5,
    parameter int NUM_TRAPS      = 1,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1),
    parameter int ID_W           = (NUM_TRAPS > 1) ? $clog2(NUM_TRAPS) : 1
) (
    input  logic                 clk,
    input  logic                 power_on_reset,
    input  logic [NUM_TRAPS-1:0] trap,
    input  logic                 pass_req,
    output logic                 sys_reset,
    output logic                 running,
    output logic                 done,
    output logic [1:0]           status,
    output logic [ID_W-1:0]      trap_id,
    output logic [CNT_W-1:0]     cycles
);

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_PASS    = 2'b01,
        ST_TRAP    = 2'b10,
        ST_TIMEOUT = 2'b11
    } status_t;

    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    // Terminal counts, pre-sized to their counters.
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // With no drain window the verdict goes straight to DONE.
    localparam state_t EXIT_STATE = (DRAIN_CYCLES > 0) ? S_DRAIN : S_DONE;

    state_t            state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [DRN_W-1:0]  drn_cnt_q, drn_cnt_d;
    logic [CNT_W-1:0]  cycles_d;
    logic [1:0]        status_d;
    logic [ID_W-1:0]   trap_id_d;
    logic              trap_any;
    logic [ID_W-1:0]   trap_low;

    // Lowest-index set trap bit; scanning downward lets the lowest win.
    always_comb begin
        trap_any = |trap;
        trap_low = '0;
        for (int i = NUM_TRAPS - 1; i >= 0; i--) begin
            if (trap[i]) trap_low = ID_W'(i);
        end
    end

    // Next-state and next-output logic for the run FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        drn_cnt_d = drn_cnt_q;
        cycles_d  = cycles;
        status_d  = status;
        trap_id_d = trap_id;

        case (state_q)
            S_RESET: begin
                if (rst_cnt_q == RST_LAST) state_d = S_RUN;
                else                       rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
            S_RUN: begin
                if (trap_any) begin
                    status_d  = ST_TRAP;
                    trap_id_d = trap_low;
                    state_d   = EXIT_STATE;
                end else if (pass_req) begin
                    status_d = ST_PASS;
                    state_d  = EXIT_STATE;
                end else if (cycles == CYC_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = EXIT_STATE;
                end else begin
                    cycles_d = cycles + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (drn_cnt_q == DRN_LAST) state_d = S_DONE;
                else                       drn_cnt_d = drn_cnt_q + DRN_W'(1);
            end
            S_DONE: begin
                // Sticky: only power_on_reset leaves this state.
            end
            default: state_d = S_RESET;
        endcase
    end

    // State, counters and registered outputs; power_on_reset acts immediately.
    always_ff @(posedge clk or posedge power_on_reset) begin
        if (power_on_reset) begin
            state_q   <= S_RESET;
            rst_cnt_q <= '0;
            drn_cnt_q <= '0;
            cycles    <= '0;
            status    <= ST_NONE;
            trap_id   <= '0;
            sys_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            drn_cnt_q <= drn_cnt_d;
            cycles    <= cycles_d;
            status    <= status_d;
            trap_id   <= trap_id_d;
            sys_reset <= (state_d == S_RESET);
            running   <= (state_d == S_RUN);
            // done is raised from the settled DONE state, one edge after entry.
            done      <= (state_q == S_DONE);
        end
    end

endmodule

// File: tb/tb_f8_sim_sequencer.sv
// Directed bench for f8_sim_sequencer: three instances (defaults, 4 traps,
// no drain window) driven through one linear sequence of steps.
module tb_f8_sim_sequencer;

    logic clk = 1'b0;
    logic power_on_reset;

    // Default instance: NUM_TRAPS=1, DRAIN=5, TIMEOUT=2045.
    logic        def_trap, def_pass;
    logic        def_sys_reset, def_running, def_done;
    logic [1:0]  def_status;
    logic        def_trap_id;
    logic [10:0] def_cycles;

    // Four-trap instance.
    logic [3:0]  t4_trap;
    logic        t4_pass;
    logic        t4_sys_reset, t4_running, t4_done;
    logic [1:0]  t4_status;
    logic [1:0]  t4_trap_id;
    logic [10:0] t4_cycles;

    // No-drain instance.
    logic        d0_trap, d0_pass;
    logic        d0_sys_reset, d0_running, d0_done;
    logic [1:0]  d0_status;
    logic        d0_trap_id;
    logic [10:0] d0_cycles;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    f8_sim_sequencer u_def (
        .clk(clk), .power_on_reset(power_on_reset), .trap(def_trap), .pass_req(def_pass),
        .sys_reset(def_sys_reset), .running(def_running), .done(def_done),
        .status(def_status), .trap_id(def_trap_id), .cycles(def_cycles)
    );

    f8_sim_sequencer #(.NUM_TRAPS(4)) u_t4 (
        .clk(clk), .power_on_reset(power_on_reset), .trap(t4_trap), .pass_req(t4_pass),
        .sys_reset(t4_sys_reset), .running(t4_running), .done(t4_done),
        .status(t4_status), .trap_id(t4_trap_id), .cycles(t4_cycles)
    );

    f8_sim_sequencer #(.DRAIN_CYCLES(0)) u_d0 (
        .clk(clk), .power_on_reset(power_on_reset), .trap(d0_trap), .pass_req(d0_pass),
        .sys_reset(d0_sys_reset), .running(d0_running), .done(d0_done),
        .status(d0_status), .trap_id(d0_trap_id), .cycles(d0_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Advance n posedges; returns just after the following negedge.
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        power_on_reset = 1'b1;
        def_trap = 1'b0; def_pass = 1'b0;
        t4_trap  = 4'b0; t4_pass  = 1'b0;
        d0_trap  = 1'b0; d0_pass  = 1'b0;

        // ---- reset values while power_on_reset is held
        #12;
        check("por_sys_reset", 32'(def_sys_reset), 32'd1);
        check("por_running",   32'(def_running),   32'd0);
        check("por_done",      32'(def_done),      32'd0);
        check("por_status",    32'(def_status),    32'd0);
        check("por_trap_id",   32'(t4_trap_id),    32'd0);
        check("por_cycles",    32'(def_cycles),    32'd0);

        // ---- run 1: defaults, trap held during RESET only, ends in timeout
        @(negedge clk);
        power_on_reset = 1'b0;
        def_trap = 1'b1;
        edges(4);
        check("r1_sysrst_e4",  32'(def_sys_reset), 32'd1);
        check("r1_running_e4", 32'(def_running),   32'd0);
        def_trap = 1'b0;
        edges(1);
        check("r1_sysrst_e5",  32'(def_sys_reset), 32'd0);
        check("r1_running_e5", 32'(def_running),   32'd1);
        check("r1_cycles_e5",  32'(def_cycles),    32'd0);
        edges(2044);
        check("r1_cycles_last", 32'(def_cycles),   32'd2044);
        check("r1_status_pre",  32'(def_status),   32'd0);
        edges(1);
        check("r1_status_to",   32'(def_status),   32'd3);
        check("r1_cycles_frz",  32'(def_cycles),   32'd2044);
        check("r1_running_off", 32'(def_running),  32'd0);
        check("r1_d0_status",   32'(d0_status),    32'd3);
        edges(1);
        check("r1_d0_done",     32'(d0_done),      32'd1);
        edges(4);
        check("r1_done_e5",     32'(def_done),     32'd0);
        edges(1);
        check("r1_done_e6",     32'(def_done),     32'd1);
        check("r1_cycles_done", 32'(def_cycles),   32'd2044);
        check("r1_sysrst_done", 32'(def_sys_reset), 32'd0);

        // ---- asynchronous reset from DONE, then run 2
        #3 power_on_reset = 1'b1;
        #1;
        check("r2_async_done",   32'(def_done),      32'd0);
        check("r2_async_status", 32'(def_status),    32'd0);
        check("r2_async_cycles", 32'(def_cycles),    32'd0);
        check("r2_async_sysrst", 32'(def_sys_reset), 32'd1);
        @(negedge clk);
        power_on_reset = 1'b0;
        edges(5);
        check("r2_t4_running", 32'(t4_running), 32'd1);
        // pass with no drain window at RUN cycle 10
        edges(10);
        check("r2_d0_cycles10", 32'(d0_cycles), 32'd10);
        d0_pass = 1'b1;
        edges(1);
        d0_pass = 1'b0;
        check("r2_d0_status_pass", 32'(d0_status),  32'd1);
        check("r2_d0_done_pre",    32'(d0_done),    32'd0);
        check("r2_d0_running",     32'(d0_running), 32'd0);
        edges(1);
        check("r2_d0_done",        32'(d0_done),    32'd1);
        d0_trap = 1'b1;
        edges(1);
        d0_trap = 1'b0;
        edges(1);
        check("r2_d0_status_hold", 32'(d0_status),  32'd1);
        check("r2_d0_cycles_hold", 32'(d0_cycles),  32'd10);
        check("r2_d0_done_hold",   32'(d0_done),    32'd1);
        // single trap bit at RUN cycle 100 (14 RUN edges already elapsed)
        edges(86);
        check("r2_t4_cycles100", 32'(t4_cycles), 32'd100);
        t4_trap = 4'b0100;
        edges(1);
        t4_trap = 4'b0000;
        check("r2_t4_status",  32'(t4_status),  32'd2);
        check("r2_t4_trap_id", 32'(t4_trap_id), 32'd2);
        check("r2_t4_cycles",  32'(t4_cycles),  32'd100);
        edges(5);
        check("r2_t4_done_e5", 32'(t4_done), 32'd0);
        edges(1);
        check("r2_t4_done_e6", 32'(t4_done), 32'd1);
        check("r2_t4_cyc_frz", 32'(t4_cycles), 32'd100);

        // ---- run 3: simultaneous trap+pass, then reset mid-DRAIN
        #3 power_on_reset = 1'b1;
        @(negedge clk);
        power_on_reset = 1'b0;
        edges(5);
        edges(20);
        t4_trap = 4'b1010;
        t4_pass = 1'b1;
        edges(1);
        t4_trap = 4'b0000;
        t4_pass = 1'b0;
        check("r3_sim_status",  32'(t4_status),  32'd2);
        check("r3_sim_trap_id", 32'(t4_trap_id), 32'd1);
        check("r3_sim_cycles",  32'(t4_cycles),  32'd20);
        edges(2);
        #2 power_on_reset = 1'b1;
        #1;
        check("r3_mid_sysrst",  32'(t4_sys_reset), 32'd1);
        check("r3_mid_status",  32'(t4_status),    32'd0);
        check("r3_mid_trap_id", 32'(t4_trap_id),   32'd0);
        check("r3_mid_cycles",  32'(t4_cycles),    32'd0);
        check("r3_mid_done",    32'(t4_done),      32'd0);

        // ---- run 4: full new reset sequence, trap on the timeout edge
        @(negedge clk);
        power_on_reset = 1'b0;
        edges(4);
        check("r4_sysrst_e4", 32'(t4_sys_reset), 32'd1);
        edges(1);
        check("r4_sysrst_e5", 32'(t4_sys_reset), 32'd0);
        check("r4_running",   32'(t4_running),   32'd1);
        edges(2044);
        check("r4_def_cycles", 32'(def_cycles), 32'd2044);
        def_trap = 1'b1;
        edges(1);
        def_trap = 1'b0;
        check("r4_trap_on_to",   32'(def_status),  32'd2);
        check("r4_trap_to_cyc",  32'(def_cycles),  32'd2044);
        check("r4_t4_status_to", 32'(t4_status),   32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
